// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode enum, FSM states and result flags.
// The multiply opcode is only implemented when ALU_MUL_EN is defined.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASS_B = 3'b000,
        OP_ILL    = 3'b001,
        OP_ADD    = 3'b010,
        OP_SUB    = 3'b011,
        OP_AND    = 3'b100,
        OP_OR     = 3'b101,
        OP_XOR    = 3'b110,
        OP_MUL    = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
        logic carry_out;
    } alu_flags_t;

    function automatic alu_flags_t make_flags(input logic msb, input logic is_zero,
                                              input logic ovf, input logic cout);
        alu_flags_t f;
        f.negative  = msb;
        f.zero      = is_zero;
        f.overflow  = ovf;
        f.carry_out = cout;
        return f;
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor with carry-out and signed overflow.
// Subtraction is a + ~b + 1, so carry_out = 1 means no borrow.
module alu_addsub #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtr,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] w_b_eff;

    assign w_b_eff     = subtr ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, subtr};
    // Signed overflow: both addends share a sign that the sum does not.
    assign ovf = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU with single-cycle ops and, when ALU_MUL_EN is defined,
// a WIDTH-cycle shift-add multiplier sharing the add/sub datapath.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       cntrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    alu_state_e       r_state;
    alu_state_e       w_next;
    alu_op_e          r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_last;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_subtr;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;
    alu_flags_t       w_flags;

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_DONE);

`ifdef ALU_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;

    assign w_is_mul = (alu_op_e'(cntrl) == OP_MUL);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    // While BUSY the adder accumulates the shifted multiplicand.
    assign w_add_a  = (r_state == ST_BUSY) ? r_acc : r_a;
    assign w_add_b  = (r_state == ST_BUSY) ? (r_b[0] ? r_a : {WIDTH{1'b0}}) : r_b;
    assign w_subtr  = (r_state != ST_BUSY) && (r_op == OP_SUB);
`else
    assign w_is_mul = 1'b0;
    assign w_last   = 1'b1;
    assign w_add_a  = r_a;
    assign w_add_b  = r_b;
    assign w_subtr  = (r_op == OP_SUB);
`endif

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a     (w_add_a),
        .b     (w_add_b),
        .subtr (w_subtr),
        .sum   (w_sum),
        .cout  (w_cout),
        .ovf   (w_ovf)
    );

    // Next-state logic for the IDLE/BUSY/DONE handshake FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next = w_is_mul ? ST_BUSY : ST_DONE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready && in_valid) begin
                    w_next = w_is_mul ? ST_BUSY : ST_DONE;
                end else if (out_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, operand capture and multiply iteration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_PASS_B;
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
`ifdef ALU_MUL_EN
            r_acc   <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a <= a;
                r_b <= b;
                r_op <= alu_op_e'(cntrl);
`ifdef ALU_MUL_EN
                r_acc <= {WIDTH{1'b0}};
                r_cnt <= {CW{1'b0}};
            end else if (r_state == ST_BUSY) begin
                r_acc <= w_sum;
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt + CW'(1);
`endif
            end
        end
    end

    // Result and flag selection from the captured operands.
    always_comb begin
        w_res = {WIDTH{1'b0}};
        w_flags = make_flags(1'b0, 1'b0, 1'b0, 1'b0);
        case (r_op)
            OP_PASS_B: w_res = r_b;
            OP_ADD,
            OP_SUB:    w_res = w_sum;
            OP_AND:    w_res = r_a & r_b;
            OP_OR:     w_res = r_a | r_b;
            OP_XOR:    w_res = r_a ^ r_b;
`ifdef ALU_MUL_EN
            OP_MUL:    w_res = r_acc;
`endif
            default:   w_res = {WIDTH{1'b0}};
        endcase
        if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
            w_flags = make_flags(w_res[WIDTH-1], (w_res == {WIDTH{1'b0}}), w_ovf, w_cout);
        end else begin
            w_flags = make_flags(w_res[WIDTH-1], (w_res == {WIDTH{1'b0}}), 1'b0, 1'b0);
        end
    end

    // Outputs read as zero whenever no result is being presented.
    assign result    = out_valid ? w_res : {WIDTH{1'b0}};
    assign negative  = out_valid && w_flags.negative;
    assign zero      = out_valid && w_flags.zero;
    assign overflow  = out_valid && w_flags.overflow;
    assign carry_out = out_valid && w_flags.carry_out;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe: an 8-bit instance for most
// scenarios and a 64-bit instance for the wide carry case.
module tb_alu_pipe;

    localparam logic [2:0] C_PASS = 3'b000;
    localparam logic [2:0] C_ILL  = 3'b001;
    localparam logic [2:0] C_ADD  = 3'b010;
    localparam logic [2:0] C_SUB  = 3'b011;
    localparam logic [2:0] C_AND  = 3'b100;
    localparam logic [2:0] C_OR   = 3'b101;
    localparam logic [2:0] C_XOR  = 3'b110;
    localparam logic [2:0] C_MUL  = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [2:0]  cntrl = 3'b000;
    logic [7:0]  a = 8'h00, b = 8'h00, result;
    logic        negative, zero, overflow, carry_out;

    logic        in_valid64 = 1'b0, in_ready64, out_valid64, out_ready64 = 1'b1;
    logic [2:0]  cntrl64 = 3'b000;
    logic [63:0] a64 = 64'h0, b64 = 64'h0, result64;
    logic        negative64, zero64, overflow64, carry_out64;

    int n_tests = 0;
    int n_fail  = 0;

    // {op, a, b, expected result, negative, zero}
    logic [28:0] logic_vec [6] = '{
        {3'b100, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0},
        {3'b101, 8'hF0, 8'h3C, 8'hFC, 1'b1, 1'b0},
        {3'b110, 8'hF0, 8'h3C, 8'hCC, 1'b1, 1'b0},
        {3'b110, 8'h55, 8'h55, 8'h00, 1'b0, 1'b1},
        {3'b000, 8'hFF, 8'h5A, 8'h5A, 1'b0, 1'b0},
        {3'b001, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1}
    };

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cntrl(cntrl), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .negative(negative), .zero(zero), .overflow(overflow),
        .carry_out(carry_out)
    );

    alu_pipe #(.WIDTH(64)) u_dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .cntrl(cntrl64), .a(a64), .b(b64), .out_valid(out_valid64), .out_ready(out_ready64),
        .result(result64), .negative(negative64), .zero(zero64), .overflow(overflow64),
        .carry_out(carry_out64)
    );

    // {out_valid, in_ready, result, N, Z, V, C}
    function automatic logic [13:0] obs8();
        return {out_valid, in_ready, result, negative, zero, overflow, carry_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb);
        in_valid = 1'b1;
        cntrl    = op;
        a        = va;
        b        = vb;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if (obs8() !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state8: got %h expected %h", obs8(), 14'h1000);
        end
        n_tests++;
        if ({out_valid64, result64, zero64, carry_out64} !== 67'h0) begin
            n_fail++;
            $display("FAIL reset_state64: got valid=%b result=%h", out_valid64, result64);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(C_ADD, 8'h7F, 8'h01);
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (obs8() !== {1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ovf: got %h expected %h", obs8(), {1'b1, 1'b1, 8'h80, 4'b1010});
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_sub();
        drive(C_SUB, 8'h05, 8'h05);
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (obs8() !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_zero: got %h expected %h", obs8(), {2'b11, 8'h00, 4'b0101});
        end
        tick();
        drive(C_SUB, 8'h00, 8'h01);
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (obs8() !== {1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h expected %h", obs8(), {2'b11, 8'hFF, 4'b1000});
        end
        tick();
    endtask

    task automatic test_logic();
        logic [28:0] v;
        for (int i = 0; i < 6; i++) begin
            v = logic_vec[i];
            drive(v[28:26], v[25:18], v[17:10]);
            tick();
            in_valid = 1'b0;
            n_tests++;
            if (obs8() !== {1'b1, 1'b1, v[9:2], v[1], v[0], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL logic_%0d: got %h expected %h", i, obs8(),
                         {1'b1, 1'b1, v[9:2], v[1], v[0], 2'b00});
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(C_XOR, 8'hF0, 8'h3C);
        tick();
        drive(C_AND, 8'hAA, 8'h0F);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (obs8() !== {1'b1, 1'b0, 8'hCC, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got %h expected %h", i, obs8(), {2'b10, 8'hCC, 4'b1000});
            end
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (obs8() !== {1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_queued_and: got %h expected %h", obs8(), {2'b11, 8'h0A, 4'b0000});
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(C_ADD, 8'h01, 8'h02);
        tick();
        n_tests++;
        if (obs8() !== {1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_add: got %h expected %h", obs8(), {2'b11, 8'h03, 4'b0000});
        end
        drive(C_SUB, 8'h09, 8'h04);
        tick();
        n_tests++;
        if (obs8() !== {1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_sub: got %h expected %h", obs8(), {2'b11, 8'h05, 4'b0001});
        end
        drive(C_OR, 8'h0F, 8'h30);
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (obs8() !== {1'b1, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_or: got %h expected %h", obs8(), {2'b11, 8'h3F, 4'b0000});
        end
        tick();
    endtask

    task automatic test_mul();
        out_ready = 1'b1;
        drive(C_MUL, 8'h0D, 8'h0B);
        tick();
        in_valid = 1'b0;
`ifdef ALU_MUL_EN
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if ({out_valid, in_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL mul_busy_%0d: got %b expected 00", i, {out_valid, in_ready});
            end
            tick();
        end
        n_tests++;
        if (obs8() !== {1'b1, 1'b1, 8'h8F, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_result: got %h expected %h", obs8(), {2'b11, 8'h8F, 4'b1000});
        end
`else
        n_tests++;
        if (obs8() !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL op111_illegal: got %h expected %h", obs8(), {2'b11, 8'h00, 4'b0100});
        end
`endif
        tick();
    endtask

    task automatic test_reset_abort();
`ifdef ALU_MUL_EN
        out_ready = 1'b1;
        drive(C_MUL, 8'h0D, 8'h0B);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
`else
        out_ready = 1'b0;
        drive(C_ADD, 8'h11, 8'h22);
        tick();
        in_valid = 1'b0;
        tick();
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_state: got %b expected 01", {out_valid, in_ready});
        end
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_valid: got %b expected 0", out_valid);
        end
        drive(C_ADD, 8'h02, 8'h03);
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (obs8() !== {1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_then_add: got %h expected %h", obs8(), {2'b11, 8'h05, 4'b0000});
        end
        tick();
    endtask

    task automatic test_wide();
        out_ready64 = 1'b1;
        in_valid64  = 1'b1;
        cntrl64     = C_ADD;
        a64         = 64'hFFFF_FFFF_FFFF_FFFF;
        b64         = 64'h0000_0000_0000_0001;
        tick();
        in_valid64 = 1'b0;
        n_tests++;
        if ({out_valid64, result64, negative64, zero64, overflow64, carry_out64} !==
            {1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL wide_add_carry: got valid=%b result=%h NZVC=%b%b%b%b expected 1 0 0101",
                     out_valid64, result64, negative64, zero64, overflow64, carry_out64);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_backpressure();
        test_back_to_back();
        test_mul();
        test_reset_abort();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
